// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - Bit indices into the write-back and memory-access control fields.
//   - Wait-FSM state encoding.
//   - The record captured when an access is launched. It is replayed into
//     MEM/WB when the access completes.
package mem_stage_pkg;

    // writeBackControlIn bit positions
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // memAccessControlIn bit positions
    localparam int MA_READ  = 1;
    localparam int MA_WRITE = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Instruction context held while the memory access is outstanding
    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  rd;
        logic [31:0] result;
    } wb_hold_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts the cycles spent waiting for a memory acknowledge.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : forces the count to zero on the next edge (wins over enable)
//   enable   : increments the count on the next edge
//   expired  : high while the current cycle is the MAX_WAIT-th waiting cycle.
//              An edge in this cycle without an acknowledge ends the access,
//              so the request is held for exactly MAX_WAIT cycles.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage.
// Takes the EX/MEM bundle and drives the MEM/WB register. The MEM/WB register
// also feeds forwarding into Execute. Loads and stores go through a req/ack
// data-memory port. While an access is outstanding, stall holds upstream. An
// access that gets no acknowledge within MAX_WAIT cycles is abandoned, and
// the sticky memFault is raised.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   writeBackControlIn[1:0]         {regWrite, memToReg}
//   memAccessControlIn[1:0]         {memRead, memWrite}
//   result, writeData, rdIn         ALU result/address, store data, destination
//   stall                           high while waiting on memory
//   memReq/memWe/memAddr/memWdata   registered memory request
//   memRdata, memAck                memory response
//   memWbRegWrite/memWbRd/memWbData MEM/WB register
//   memFault                        sticky timeout flag
module memory_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            writeBackControlIn,
    input  logic [1:0]            memAccessControlIn,
    input  logic [31:0]           result,
    input  logic [31:0]           writeData,
    input  logic [4:0]            rdIn,
    output logic                  stall,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [31:0]           memWdata,
    input  logic [31:0]           memRdata,
    input  logic                  memAck,
    output logic                  memWbRegWrite,
    output logic [4:0]            memWbRd,
    output logic [31:0]           memWbData,
    output logic                  memFault
);

    mem_state_e            state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    wb_hold_t              hold_q, hold_d;
    logic                  wb_reg_write_q, wb_reg_write_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic [31:0]           wb_data_q, wb_data_d;
    logic                  fault_q, fault_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk     (clk),
        .rst     (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        hold_d         = hold_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        fault_d        = fault_q;
        timer_clear    = 1'b1;
        timer_enable   = 1'b0;

        case (state_q)
            IDLE: begin
                if (memAccessControlIn != 2'b00) begin
                    state_d     = WAIT;
                    mem_req_d   = 1'b1;
                    // A read and a write together are treated as a read.
                    mem_we_d    = memAccessControlIn[MA_WRITE] & ~memAccessControlIn[MA_READ];
                    mem_addr_d  = result[ADDR_WIDTH-1:0];
                    mem_wdata_d = writeData;
                    hold_d      = '{reg_write:  writeBackControlIn[WB_REGWRITE],
                                    mem_to_reg: writeBackControlIn[WB_MEMTOREG],
                                    rd:         rdIn,
                                    result:     result};
                    // Bubble: rd/data keep their old values, so only
                    // regWrite has to drop.
                    wb_reg_write_d = 1'b0;
                end else begin
                    wb_reg_write_d = writeBackControlIn[WB_REGWRITE];
                    wb_rd_d        = rdIn;
                    wb_data_d      = result;
                end
            end
            WAIT: begin
                timer_clear  = 1'b0;
                timer_enable = 1'b1;
                // An acknowledge in the final allowed cycle still counts as success.
                if (memAck) begin
                    state_d        = IDLE;
                    mem_req_d      = 1'b0;
                    timer_clear    = 1'b1;
                    wb_reg_write_d = hold_q.reg_write;
                    wb_rd_d        = hold_q.rd;
                    wb_data_d      = hold_q.mem_to_reg ? memRdata : hold_q.result;
                end else if (timer_expired) begin
                    state_d        = IDLE;
                    mem_req_d      = 1'b0;
                    fault_d        = 1'b1;
                    timer_clear    = 1'b1;
                    wb_reg_write_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            hold_q         <= '0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            hold_q         <= hold_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            fault_q        <= fault_d;
        end
    end

    assign stall         = (state_q == WAIT);
    assign memReq        = mem_req_q;
    assign memWe         = mem_we_q;
    assign memAddr       = mem_addr_q;
    assign memWdata      = mem_wdata_q;
    assign memWbRegWrite = wb_reg_write_q;
    assign memWbRd       = wb_rd_q;
    assign memWbData     = wb_data_q;
    assign memFault      = fault_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed testbench for memory_access_stage: table of ALU pass-through
// vectors plus hand-written load/store/timeout/reset/back-to-back sequences.
module tb_memory_access_stage;

    logic        clk;
    logic        reset;
    logic [1:0]  writeBackControlIn;
    logic [1:0]  memAccessControlIn;
    logic [31:0] result;
    logic [31:0] writeData;
    logic [4:0]  rdIn;
    logic        stall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memAck;
    logic        memWbRegWrite;
    logic [4:0]  memWbRd;
    logic [31:0] memWbData;
    logic        memFault;

    int tests_run = 0;
    int tests_failed = 0;

    memory_access_stage #(
        .ADDR_WIDTH (32),
        .MAX_WAIT   (15)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .writeBackControlIn (writeBackControlIn),
        .memAccessControlIn (memAccessControlIn),
        .result             (result),
        .writeData          (writeData),
        .rdIn               (rdIn),
        .stall              (stall),
        .memReq             (memReq),
        .memWe              (memWe),
        .memAddr            (memAddr),
        .memWdata           (memWdata),
        .memRdata           (memRdata),
        .memAck             (memAck),
        .memWbRegWrite      (memWbRegWrite),
        .memWbRd            (memWbRd),
        .memWbData          (memWbData),
        .memFault           (memFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", name, act);
        end
    endtask

    // Advance one edge, then settle 1 time unit so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wb, input logic [1:0] ma, input logic [31:0] res,
                         input logic [31:0] wd, input logic [4:0] rd);
        writeBackControlIn = wb;
        memAccessControlIn = ma;
        result             = res;
        writeData          = wd;
        rdIn               = rd;
    endtask

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        exp_rw;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } alu_vec_t;

    alu_vec_t vecs[5];
    int       req_cycles;

    initial begin
        vecs[0] = '{wb: 2'b10, res: 32'd270,        rd: 5'd0,  exp_rw: 1'b1, exp_rd: 5'd0,  exp_data: 32'd270};
        vecs[1] = '{wb: 2'b00, res: 32'h1234_5678,  rd: 5'd9,  exp_rw: 1'b0, exp_rd: 5'd9,  exp_data: 32'h1234_5678};
        vecs[2] = '{wb: 2'b11, res: 32'hFFFF_FFFF,  rd: 5'd31, exp_rw: 1'b1, exp_rd: 5'd31, exp_data: 32'hFFFF_FFFF};
        vecs[3] = '{wb: 2'b10, res: 32'h0000_0001,  rd: 5'd17, exp_rw: 1'b1, exp_rd: 5'd17, exp_data: 32'h0000_0001};
        vecs[4] = '{wb: 2'b01, res: 32'hA5A5_0000,  rd: 5'd4,  exp_rw: 1'b0, exp_rd: 5'd4,  exp_data: 32'hA5A5_0000};

        reset    = 1'b1;
        memAck   = 1'b0;
        memRdata = '0;
        drive(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
        #3;
        chk("reset_memReq",   {31'd0, memReq},        32'd0);
        chk("reset_stall",    {31'd0, stall},         32'd0);
        chk("reset_wbRw",     {31'd0, memWbRegWrite}, 32'd0);
        chk("reset_wbData",   memWbData,              32'd0);
        chk("reset_fault",    {31'd0, memFault},      32'd0);
        #9;
        reset = 1'b0;

        // ALU pass-through table
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].wb, 2'b00, vecs[i].res, 32'h0, vecs[i].rd);
            step();
            chk($sformatf("alu%0d_rw", i),    {31'd0, memWbRegWrite}, {31'd0, vecs[i].exp_rw});
            chk($sformatf("alu%0d_rd", i),    {27'd0, memWbRd},       {27'd0, vecs[i].exp_rd});
            chk($sformatf("alu%0d_data", i),  memWbData,              vecs[i].exp_data);
            chk($sformatf("alu%0d_stall", i), {31'd0, stall},         32'd0);
            chk($sformatf("alu%0d_req", i),   {31'd0, memReq},        32'd0);
        end

        // Load, ack two cycles after request
        drive(2'b11, 2'b10, 32'h40, 32'h0, 5'd3);
        step();
        chk("load_req",   {31'd0, memReq},        32'd1);
        chk("load_we",    {31'd0, memWe},         32'd0);
        chk("load_addr",  memAddr,                32'h40);
        chk("load_stall", {31'd0, stall},         32'd1);
        chk("load_bubble",{31'd0, memWbRegWrite}, 32'd0);
        step();
        chk("load_wait_req",   {31'd0, memReq}, 32'd1);
        chk("load_wait_stall", {31'd0, stall},  32'd1);
        memAck = 1'b1; memRdata = 32'hDEADBEEF;
        step();
        memAck = 1'b0;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        chk("load_done_req",   {31'd0, memReq},        32'd0);
        chk("load_done_stall", {31'd0, stall},         32'd0);
        chk("load_done_rw",    {31'd0, memWbRegWrite}, 32'd1);
        chk("load_done_rd",    {27'd0, memWbRd},       32'd3);
        chk("load_done_data",  memWbData,              32'hDEADBEEF);

        // Store, ack in the first WAIT cycle
        drive(2'b00, 2'b01, 32'h10, 32'h55, 5'd8);
        step();
        chk("store_req",   {31'd0, memReq}, 32'd1);
        chk("store_we",    {31'd0, memWe},  32'd1);
        chk("store_addr",  memAddr,         32'h10);
        chk("store_wdata", memWdata,        32'h55);
        chk("store_stall", {31'd0, stall},  32'd1);
        memAck = 1'b1; memRdata = 32'h9999_9999;
        step();
        memAck = 1'b0;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        chk("store_done_req",   {31'd0, memReq},        32'd0);
        chk("store_done_stall", {31'd0, stall},         32'd0);
        chk("store_done_rw",    {31'd0, memWbRegWrite}, 32'd0);
        chk("store_done_data",  memWbData,              32'h10);

        // Read and write together: treated as read
        drive(2'b10, 2'b11, 32'h24, 32'h77, 5'd2);
        step();
        drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        chk("rw_both_req", {31'd0, memReq}, 32'd1);
        chk("rw_both_we",  {31'd0, memWe},  32'd0);
        memAck = 1'b1; memRdata = 32'h0;
        step();
        memAck = 1'b0;
        chk("rw_both_done_data", memWbData, 32'h24);

        // Timeout: request held exactly 15 cycles, then fault
        drive(2'b11, 2'b10, 32'h50, 32'h0, 5'd12);
        step();
        drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!memReq) break;
            req_cycles++;
            step();
        end
        chk("timeout_req_cycles", req_cycles,             32'd15);
        chk("timeout_req",        {31'd0, memReq},        32'd0);
        chk("timeout_fault",      {31'd0, memFault},      32'd1);
        chk("timeout_rw",         {31'd0, memWbRegWrite}, 32'd0);
        chk("timeout_stall",      {31'd0, stall},         32'd0);
        memAck = 1'b1; memRdata = 32'h1111_2222;
        step();
        memAck = 1'b0;
        chk("late_ack_req",   {31'd0, memReq},        32'd0);
        chk("late_ack_rw",    {31'd0, memWbRegWrite}, 32'd0);
        chk("late_ack_data",  memWbData,              32'h0);
        chk("late_ack_fault", {31'd0, memFault},      32'd1);
        step();
        chk("fault_sticky",   {31'd0, memFault},      32'd1);

        // Reset asserted mid-WAIT
        drive(2'b11, 2'b10, 32'h60, 32'h0, 5'd14);
        step();
        chk("pre_reset_req", {31'd0, memReq}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_req",   {31'd0, memReq},        32'd0);
        chk("async_reset_stall", {31'd0, stall},         32'd0);
        chk("async_reset_rw",    {31'd0, memWbRegWrite}, 32'd0);
        chk("async_reset_rd",    {27'd0, memWbRd},       32'd0);
        chk("async_reset_data",  memWbData,              32'd0);
        chk("async_reset_fault", {31'd0, memFault},      32'd0);
        drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        #2;
        reset = 1'b0;
        step();
        chk("post_reset_req", {31'd0, memReq}, 32'd0);
        drive(2'b11, 2'b10, 32'h80, 32'h0, 5'd21);
        step();
        drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        chk("fresh_req",  {31'd0, memReq}, 32'd1);
        chk("fresh_addr", memAddr,         32'h80);
        memAck = 1'b1; memRdata = 32'h0BAD_F00D;
        step();
        memAck = 1'b0;
        chk("fresh_rd",   {27'd0, memWbRd}, 32'd21);
        chk("fresh_data", memWbData,        32'h0BAD_F00D);

        // Back-to-back: ALU A, load, ALU B held by stall
        drive(2'b10, 2'b00, 32'd111, 32'h0, 5'd5);
        step();
        chk("b2b_A_rd",   {27'd0, memWbRd}, 32'd5);
        chk("b2b_A_data", memWbData,        32'd111);
        drive(2'b11, 2'b10, 32'h20, 32'h0, 5'd6);
        step();
        chk("b2b_ld_stall",  {31'd0, stall},         32'd1);
        chk("b2b_ld_bubble", {31'd0, memWbRegWrite}, 32'd0);
        drive(2'b10, 2'b00, 32'd222, 32'h0, 5'd7);
        step();
        chk("b2b_wait_rw",   {31'd0, memWbRegWrite}, 32'd0);
        chk("b2b_wait_rd",   {27'd0, memWbRd},       32'd5);
        memAck = 1'b1; memRdata = 32'h0000_CAFE;
        step();
        memAck = 1'b0;
        chk("b2b_ld_rw",    {31'd0, memWbRegWrite}, 32'd1);
        chk("b2b_ld_rd",    {27'd0, memWbRd},       32'd6);
        chk("b2b_ld_data",  memWbData,              32'h0000_CAFE);
        chk("b2b_ld_stall_rel", {31'd0, stall},     32'd0);
        step();
        chk("b2b_B_rw",   {31'd0, memWbRegWrite}, 32'd1);
        chk("b2b_B_rd",   {27'd0, memWbRd},       32'd7);
        chk("b2b_B_data", memWbData,              32'd222);
        drive(2'b00, 2'b00, 32'd0, 32'h0, 5'd0);
        step();
        chk("b2b_after_rw", {31'd0, memWbRegWrite}, 32'd0);
        chk("b2b_after_req",{31'd0, memReq},        32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
